// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   serial_state_e   : controller state (IDLE, RUN)
//   SERIAL_WIDTH_DEF : default operand width of the serial adder
// -----------------------------------------------------------------------------
package serial_arith_pkg;

   localparam int SERIAL_WIDTH_DEF = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } serial_state_e;

endpackage : serial_arith_pkg

// File: rtl/serial_adder_full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// One-bit combinational full adder used as the per-bit slice of the serial
// adder.
//   x, y : operand bits
//   cin  : carry in
//   s    : sum bit
//   co   : carry out (majority of x, y, cin)
// -----------------------------------------------------------------------------
module full_adder_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ cin;
   assign co = (x & y) | (x & cin) | (y & cin);

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial unsigned adder: one bit per clock, LSB first, single carry flop,
// start/busy/done handshake.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (aborts any operation, no done)
//   start : request a new addition, sampled only while idle
//   a, b  : operands, captured on the accepting edge
//   busy  : high for exactly WIDTH cycles while bits are processed
//   done  : one-cycle pulse, sum/cout valid
//   sum   : (a+b) mod 2^WIDTH, held until the next accept
//   cout  : carry out of bit WIDTH-1, updated only on the last-bit edge
// -----------------------------------------------------------------------------
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = SERIAL_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);

   serial_state_e    state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_s;
   logic             fa_co;

   // Per-bit slice works on the current LSBs of the operand shift registers.
   full_adder_bit u_fa (
      .x   (ra_q[0]),
      .y   (rb_q[0]),
      .cin (carry_q),
      .s   (fa_s),
      .co  (fa_co)
   );

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= {CW{1'b0}};
         ra_q    <= {WIDTH{1'b0}};
         rb_q    <= {WIDTH{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: accept in IDLE, one bit per cycle in RUN.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               carry_d = 1'b0;
               count_d = {CW{1'b0}};
               state_d = RUN;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Shifts are written as >>/<< so WIDTH=1 needs no special case.
            ra_d    = ra_q >> 1;
            rb_d    = rb_q >> 1;
            sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
            carry_d = fa_co;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cout_d  = fa_co;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder: a WIDTH=8 instance and a WIDTH=1
// instance, checked against plain integer addition.
// -----------------------------------------------------------------------------
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start1;
   logic [7:0] a8, b8, sum8;
   logic [0:0] a1, b1, sum1;
   logic       busy8, done8, cout8;
   logic       busy1, done1, cout1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // One WIDTH=8 addition. inj_at >= 0 raises start (a=AA) in that busy cycle;
   // rst_at >= 0 asserts reset in that busy cycle.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input int inj_at, input int rst_at);
      logic [8:0] model;
      int busy_cyc, done_at, done_cnt;
      model = {1'b0, a} + {1'b0, b};
      a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      busy_cyc = 0; done_at = -1; done_cnt = 0;
      for (int j = 0; j < 20; j++) begin
         if (rst_at >= 0 && j == rst_at + 1) begin
            rst = 1'b0;
            check_value("rst_busy", busy8, 0);
            check_value("rst_done", done8, 0);
            check_value("rst_sum",  sum8,  0);
            check_value("rst_cout", cout8, 0);
         end
         if (busy8) busy_cyc++;
         if (done8) begin
            if (done_at < 0) done_at = j;
            done_cnt++;
         end
         start8 = 1'b0;
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         if (j == inj_at) begin
            start8 = 1'b1;
            a8 = 8'hAA;
         end
         if (j == rst_at) rst = 1'b1;
         @(negedge clk);
      end
      if (rst_at >= 0) begin
         check_value("rst_no_done", done_cnt, 0);
      end else begin
         check_value("busy_cycles", busy_cyc, 8);
         check_value("done_latency", done_at, 8);
         check_value("done_count", done_cnt, 1);
         check_value("sum8", sum8, model[7:0]);
         check_value("cout8", cout8, model[8]);
      end
   endtask

   // One WIDTH=1 addition.
   task automatic run1(input logic a, input logic b);
      logic [1:0] model;
      int busy_cyc, done_at, done_cnt;
      model = {1'b0, a} + {1'b0, b};
      a1 = a; b1 = b; start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      busy_cyc = 0; done_at = -1; done_cnt = 0;
      for (int j = 0; j < 6; j++) begin
         if (busy1) busy_cyc++;
         if (done1) begin
            if (done_at < 0) done_at = j;
            done_cnt++;
         end
         a1 = 1'($urandom);
         b1 = 1'($urandom);
         @(negedge clk);
      end
      check_value("w1_busy_cycles", busy_cyc, 1);
      check_value("w1_done_latency", done_at, 1);
      check_value("w1_done_count", done_cnt, 1);
      check_value("w1_sum", sum1, model[0]);
      check_value("w1_cout", cout1, model[1]);
   endtask

   initial begin
      int t1, t2;
      rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
      a8 = 8'h5A; b8 = 8'hA5; a1 = 1'b1; b1 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("reset_busy8", busy8, 0);
      check_value("reset_done8", done8, 0);
      check_value("reset_sum8",  sum8,  0);
      check_value("reset_cout8", cout8, 0);
      check_value("reset_busy1", busy1, 0);
      check_value("reset_done1", done1, 0);
      check_value("reset_sum1",  sum1,  0);
      check_value("reset_cout1", cout1, 0);
      rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
      @(negedge clk);

      // Directed cases
      run8(8'h05, 8'h03, -1, -1);
      run8(8'hFF, 8'h01, -1, -1);
      run8(8'hFF, 8'hFF, -1, -1);
      run8(8'h10, 8'h20, 2, -1);
      run8(8'h7F, 8'h01, -1, 3);
      run8(8'h7F, 8'h01, -1, -1);

      // Back-to-back with start held high
      start8 = 1'b1; a8 = 8'd12; b8 = 8'd34;
      @(posedge clk);
      @(negedge clk);
      t1 = -1; t2 = -1;
      for (int j = 0; j < 30; j++) begin
         if (done8) begin
            if (t1 < 0) begin
               t1 = j;
               check_value("b2b_sum1", sum8, 46);
               check_value("b2b_cout1", cout8, 0);
               a8 = 8'd200; b8 = 8'd100;
            end else if (t2 < 0) begin
               t2 = j;
               check_value("b2b_sum2", sum8, 44);
               check_value("b2b_cout2", cout8, 1);
               start8 = 1'b0;
            end
         end
         @(negedge clk);
      end
      start8 = 1'b0;
      check_value("b2b_first_latency", t1, 8);
      check_value("b2b_period", t2 - t1, 9);

      // Randomized cases
      for (int k = 0; k < 30; k++)
         run8(8'($urandom), 8'($urandom), -1, -1);

      // WIDTH=1: directed then exhaustive
      run1(1'b1, 1'b1);
      for (int k = 0; k < 4; k++)
         run1(k[1], k[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_serial_adder
